// File: rtl/bpu_update_fifo.sv
// Ordered buffer between the branch resolver and the BPU table-update port.
// Optional statistics counters are enabled with `define BPU_UPD_STAT_EN.
package bpu_pkg;
    typedef struct packed {
        logic        need_update;
        logic        miss;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
    } bpu_correct_t;
endpackage

module bpu_update_fifo
    import bpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  bpu_correct_t       correct_i,
    output logic               update_valid_o,
    output bpu_correct_t       update_o,
    input  logic               update_ready_i,
    output logic [PTR_W:0]     count_o,
`ifdef BPU_UPD_STAT_EN
    output logic [31:0]        stat_enq_o,
    output logic [31:0]        stat_miss_o,
    output logic [31:0]        stat_drop_o,
`endif
    output logic               drop_o
);

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    bpu_correct_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] youngest;
    logic             enq, deq, push, ovw, drop;

    assign enq      = valid_i && correct_i.need_update;
    assign deq      = (count_q != '0) && update_ready_i;
    assign youngest = tail_q - PTR_W'(1);

    always_comb begin
        push    = 1'b0;
        ovw     = 1'b0;
        drop    = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            // Free space is judged after this cycle's dequeue.
            if ((count_q != FullCnt) || deq) begin
                push = 1'b1;
            end else if (correct_i.miss && !mem_q[youngest].miss) begin
                ovw  = 1'b1;
                drop = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push && !deq) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (deq && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the output mux masks it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= correct_i;
        end else if (ovw) begin
            mem_q[youngest] <= correct_i;
        end
    end

    assign update_valid_o = (count_q != '0);
    assign update_o       = update_valid_o ? mem_q[head_q] : '0;
    assign count_o        = count_q;
    assign drop_o         = drop;

`ifdef BPU_UPD_STAT_EN
    logic [31:0] stat_enq_q, stat_miss_q, stat_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_enq_q  <= '0;
            stat_miss_q <= '0;
            stat_drop_q <= '0;
        end else begin
            if (push || ovw) begin
                stat_enq_q <= stat_enq_q + 32'd1;
            end
            if ((push || ovw) && correct_i.miss) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
            if (drop) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
        end
    end

    assign stat_enq_o  = stat_enq_q;
    assign stat_miss_o = stat_miss_q;
    assign stat_drop_o = stat_drop_q;
`endif

endmodule

// File: tb/tb_bpu_update_fifo.sv
// Randomised and directed bench for bpu_update_fifo against a queue-based model.
module tb_bpu_update_fifo;
    import bpu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           valid_i = 1'b0;
    bpu_correct_t   correct_i = '0;
    logic           update_valid_o;
    bpu_correct_t   update_o;
    logic           update_ready_i = 1'b0;
    logic [PTR_W:0] count_o;
    logic           drop_o;
`ifdef BPU_UPD_STAT_EN
    logic [31:0]    stat_enq_o, stat_miss_o, stat_drop_o;
`endif

    bpu_update_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .correct_i      (correct_i),
        .update_valid_o (update_valid_o),
        .update_o       (update_o),
        .update_ready_i (update_ready_i),
        .count_o        (count_o),
`ifdef BPU_UPD_STAT_EN
        .stat_enq_o     (stat_enq_o),
        .stat_miss_o    (stat_miss_o),
        .stat_drop_o    (stat_drop_o),
`endif
        .drop_o         (drop_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bpu_correct_t model_q[$];
    int unsigned  m_enq = 0, m_miss = 0, m_drop = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bpu_correct_t mk(input logic [31:0] pc, input logic miss, input logic nu);
        bpu_correct_t r;
        r.need_update = nu;
        r.miss        = miss;
        r.taken       = pc[2];
        r.target      = pc + 32'h40;
        r.pc          = pc;
        return r;
    endfunction

    // One clock: drive, check outputs mid-cycle against the model, then advance the model.
    task automatic step(input logic v, input bpu_correct_t c, input logic r);
        logic         do_deq, accept, overwrite, exp_drop;
        bpu_correct_t exp_out;
        valid_i        = v;
        correct_i      = c;
        update_ready_i = r;
        do_deq    = (model_q.size() != 0) && r;
        accept    = 1'b0;
        overwrite = 1'b0;
        exp_drop  = 1'b0;
        if (v && c.need_update) begin
            if (model_q.size() - (do_deq ? 1 : 0) < DEPTH) accept = 1'b1;
            else if (c.miss && !model_q[model_q.size()-1].miss) overwrite = 1'b1;
            exp_drop = !accept;
        end
        exp_out = (model_q.size() != 0) ? model_q[0] : '0;
        @(negedge clk);
        check("valid", 128'(update_valid_o), 128'(model_q.size() != 0));
        check("count", 128'(count_o), 128'(model_q.size()));
        check("update", 128'(update_o), 128'(exp_out));
        check("drop", 128'(drop_o), 128'(exp_drop));
        @(posedge clk);
        if (do_deq) void'(model_q.pop_front());
        if (accept) model_q.push_back(c);
        if (overwrite) model_q[model_q.size()-1] = c;
        if (accept || overwrite) begin
            m_enq++;
            if (c.miss) m_miss++;
        end
        if (exp_drop) m_drop++;
        #1;
    endtask

    task automatic check_stats();
`ifdef BPU_UPD_STAT_EN
        check("stat_enq", 128'(stat_enq_o), 128'(m_enq));
        check("stat_miss", 128'(stat_miss_o), 128'(m_miss));
        check("stat_drop", 128'(stat_drop_o), 128'(m_drop));
`endif
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) step(1'b1, mk(base + 32'(4 * i), 1'b0, 1'b1), 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(update_valid_o), 128'(0));
        check("rst_count", 128'(count_o), 128'(0));
        rst = 1'b0;

        step(1'b1, mk(32'h1c000010, 1'b0, 1'b1), 1'b1);
        check("first_valid", 128'(update_valid_o), 128'(1));
        check("first_pc", 128'(update_o.pc), 128'h1c000010);
        drain(3);

        for (int i = 0; i < 5; i++) step(1'b1, mk(32'h500 + 32'(i), 1'b1, 1'b0), 1'b0);

        fill(32'h100, 4);
        step(1'b1, mk(32'h110, 1'b0, 1'b1), 1'b0);
        drain(6);

        fill(32'h100, 4);
        step(1'b1, mk(32'h200, 1'b1, 1'b1), 1'b0);
        drain(6);
        fill(32'h100, 3);
        step(1'b1, mk(32'h200, 1'b1, 1'b1), 1'b0);
        step(1'b1, mk(32'h300, 1'b1, 1'b1), 1'b0);
        check("miss_kept", 128'(model_q[3].pc), 128'h200);
        drain(6);

        fill(32'h100, 4);
        for (int i = 0; i < 10; i++) step(1'b1, mk(32'h400 + 32'(4 * i), 1'b0, 1'b1), 1'b1);
        drain(6);

        fill(32'h600, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 128'(update_valid_o), 128'(0));
        check("arst_count", 128'(count_o), 128'(0));
        model_q.delete();
        m_enq = 0;
        m_miss = 0;
        m_drop = 0;
        check_stats();
        #1 rst = 1'b0;
        drain(4);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 mk($urandom & 32'hfffffffc, $urandom_range(0, 9) < 3, $urandom_range(0, 7) != 0),
                 $urandom_range(0, 1) == 1);
        end
        drain(6);
        check_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
